// File: rtl/match_scheduler.sv
// Sequencer for a bank of string matchers: loads weights in passes of up to MW slots,
// streams the whole string per pass, collects each pass result and hands it off.
module match_scheduler #(
    parameter int DWIDTH               = 8,
    parameter int strlen               = 50,
    parameter int num                  = 4,
    parameter int groups               = 4,
    parameter int max_number_of_weight = num * groups,
    parameter int weight_num           = 20,
    localparam int MW  = max_number_of_weight,
    localparam int WN  = weight_num,
    localparam int WAW = (WN > 1) ? $clog2(WN) : 1,
    localparam int SLW = (MW > 1) ? $clog2(MW) : 1,
    localparam int SAW = (strlen > 1) ? $clog2(strlen) : 1,
    localparam int BW  = $clog2(WN + 1),
    localparam int KW  = $clog2(MW + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              w_rd,
    output logic [WAW-1:0]    w_addr,
    input  logic [DWIDTH-1:0] w_data,
    output logic              load_en,
    output logic [SLW-1:0]    load_slot,
    output logic [DWIDTH-1:0] load_data,
    output logic [MW-1:0]     slot_valid,
    output logic              s_rd,
    output logic [SAW-1:0]    s_addr,
    input  logic [DWIDTH-1:0] s_data,
    output logic              stream_valid,
    output logic [DWIDTH-1:0] stream_data,
    output logic              stream_last,
    input  logic              match_valid,
    input  logic [MW-1:0]     match_vec,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [BW-1:0]     res_base,
    output logic [MW-1:0]     res_vec,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STREAM, S_WAIT, S_REPORT, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [BW-1:0]  base_q, base_d;
    logic [KW-1:0]  ld_k_q, ld_k_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic           w_rd_q, w_rd_d, load_en_q, load_en_d;
    logic [WAW-1:0] w_addr_q, w_addr_d;
    logic [SLW-1:0] load_slot_q, load_slot_d;
    logic [MW-1:0]  slot_valid_q, slot_valid_d;
    logic           s_rd_q, s_rd_d, stream_valid_q, stream_valid_d;
    logic           stream_last_q, stream_last_d;
    logic [SAW-1:0] s_addr_q, s_addr_d;
    logic           res_valid_q, res_valid_d;
    logic [BW-1:0]  res_base_q, res_base_d;
    logic [MW-1:0]  res_vec_q, res_vec_d;
    logic [31:0]    rem_w, cnt_w, next_base_w;

    // Pass size: a full bank, or whatever weights remain on the last pass.
    assign rem_w       = 32'(WN) - 32'(base_q);
    assign cnt_w       = (rem_w < 32'(MW)) ? rem_w : 32'(MW);
    assign next_base_w = 32'(base_q) + cnt_w;

    // Result handshake: res_valid rises with stable res_base/res_vec and holds until a
    // cycle where res_ready is high; that edge is the transfer and res_valid then drops.
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        ld_k_d         = ld_k_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        w_rd_d         = 1'b0;
        w_addr_d       = '0;
        load_en_d      = 1'b0;
        load_slot_d    = '0;
        slot_valid_d   = slot_valid_q;
        s_rd_d         = 1'b0;
        s_addr_d       = '0;
        stream_valid_d = 1'b0;
        stream_last_d  = 1'b0;
        res_valid_d    = 1'b0;
        res_base_d     = res_base_q;
        res_vec_d      = res_vec_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    base_d       = '0;
                    busy_d       = 1'b1;
                    ld_k_d       = '0;
                    slot_valid_d = '0;
                    w_rd_d       = 1'b1;
                    w_addr_d     = '0;
                end
            end
            S_LOAD: begin
                load_en_d = w_rd_q;
                if (w_rd_q) begin
                    load_slot_d                  = SLW'(ld_k_q);
                    slot_valid_d[SLW'(ld_k_q)]   = 1'b1;
                end
                if (32'(ld_k_q) + 32'd1 < cnt_w) begin
                    w_rd_d   = 1'b1;
                    w_addr_d = WAW'(32'(base_q) + 32'(ld_k_q) + 32'd1);
                end
                if (32'(ld_k_q) == cnt_w) begin
                    state_d  = S_STREAM;
                    ld_k_d   = '0;
                    s_rd_d   = 1'b1;
                    s_addr_d = '0;
                end else begin
                    ld_k_d = ld_k_q + 1'b1;
                end
            end
            S_STREAM: begin
                stream_valid_d = s_rd_q;
                stream_last_d  = s_rd_q && (s_addr_q == SAW'(strlen - 1));
                if (s_rd_q && (s_addr_q != SAW'(strlen - 1))) begin
                    s_rd_d   = 1'b1;
                    s_addr_d = s_addr_q + 1'b1;
                end
                if (stream_last_q) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (match_valid) begin
                    res_vec_d   = match_vec & slot_valid_q;
                    res_base_d  = base_q;
                    res_valid_d = 1'b1;
                    state_d     = S_REPORT;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    res_base_d = '0;
                    res_vec_d  = '0;
                    base_d     = BW'(next_base_w);
                    if (next_base_w >= 32'(WN)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = S_LOAD;
                        ld_k_d       = '0;
                        slot_valid_d = '0;
                        w_rd_d       = 1'b1;
                        w_addr_d     = WAW'(next_base_w);
                    end
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                base_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            ld_k_q         <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            w_rd_q         <= 1'b0;
            w_addr_q       <= '0;
            load_en_q      <= 1'b0;
            load_slot_q    <= '0;
            slot_valid_q   <= '0;
            s_rd_q         <= 1'b0;
            s_addr_q       <= '0;
            stream_valid_q <= 1'b0;
            stream_last_q  <= 1'b0;
            res_valid_q    <= 1'b0;
            res_base_q     <= '0;
            res_vec_q      <= '0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            ld_k_q         <= ld_k_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            w_rd_q         <= w_rd_d;
            w_addr_q       <= w_addr_d;
            load_en_q      <= load_en_d;
            load_slot_q    <= load_slot_d;
            slot_valid_q   <= slot_valid_d;
            s_rd_q         <= s_rd_d;
            s_addr_q       <= s_addr_d;
            stream_valid_q <= stream_valid_d;
            stream_last_q  <= stream_last_d;
            res_valid_q    <= res_valid_d;
            res_base_q     <= res_base_d;
            res_vec_q      <= res_vec_d;
        end
    end

    // Memory read data is only meaningful in the cycle after its strobe.
    assign load_data    = load_en_q ? w_data : '0;
    assign stream_data  = stream_valid_q ? s_data : '0;
    assign busy         = busy_q;
    assign done         = done_q;
    assign w_rd         = w_rd_q;
    assign w_addr       = w_addr_q;
    assign load_en      = load_en_q;
    assign load_slot    = load_slot_q;
    assign slot_valid   = slot_valid_q;
    assign s_rd         = s_rd_q;
    assign s_addr       = s_addr_q;
    assign stream_valid = stream_valid_q;
    assign stream_last  = stream_last_q;
    assign res_valid    = res_valid_q;
    assign res_base     = res_base_q;
    assign res_vec      = res_vec_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_match_scheduler.sv
// Directed/randomized bench for match_scheduler: default 20-weight job in two passes,
// stalled result handshake, held start, mid-stream reset, and a single-pass variant.
module tb_match_scheduler;

    localparam int WN  = 20;
    localparam int MW  = 16;
    localparam int SL  = 50;
    localparam int NP  = (WN + MW - 1) / MW;
    localparam int SL2 = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, w_rd, load_en, s_rd, stream_valid, stream_last, res_valid;
    logic [4:0]  w_addr;
    logic [7:0]  w_data = '0;
    logic [3:0]  load_slot;
    logic [7:0]  load_data;
    logic [15:0] slot_valid;
    logic [5:0]  s_addr;
    logic [7:0]  s_data = '0;
    logic [7:0]  stream_data;
    logic        match_valid = 1'b0;
    logic [15:0] match_vec = '0;
    logic        res_ready = 1'b0;
    logic [4:0]  res_base;
    logic [15:0] res_vec;
    logic [2:0]  state_dbg;

    logic        start2 = 1'b0;
    logic        busy2, done2, w_rd2, load_en2, s_rd2, stream_valid2, stream_last2, res_valid2;
    logic [3:0]  w_addr2;
    logic [7:0]  w_data2 = '0;
    logic [3:0]  load_slot2;
    logic [7:0]  load_data2;
    logic [15:0] slot_valid2;
    logic [2:0]  s_addr2;
    logic [7:0]  s_data2 = '0;
    logic [7:0]  stream_data2;
    logic        match_valid2 = 1'b0;
    logic [15:0] match_vec2 = '0;
    logic        res_ready2 = 1'b0;
    logic [4:0]  res_base2;
    logic [15:0] res_vec2;
    logic [2:0]  state_dbg2;

    logic [7:0]  wmem [WN];
    logic [7:0]  smem [SL];
    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    int          ld2_cnt = 0;
    int          ld2_bad = 0;

    match_scheduler u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
        .load_en(load_en), .load_slot(load_slot), .load_data(load_data), .slot_valid(slot_valid),
        .s_rd(s_rd), .s_addr(s_addr), .s_data(s_data),
        .stream_valid(stream_valid), .stream_data(stream_data), .stream_last(stream_last),
        .match_valid(match_valid), .match_vec(match_vec),
        .res_valid(res_valid), .res_ready(res_ready), .res_base(res_base), .res_vec(res_vec),
        .state_dbg(state_dbg)
    );

    match_scheduler #(.strlen(SL2), .weight_num(16)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .w_rd(w_rd2), .w_addr(w_addr2), .w_data(w_data2),
        .load_en(load_en2), .load_slot(load_slot2), .load_data(load_data2), .slot_valid(slot_valid2),
        .s_rd(s_rd2), .s_addr(s_addr2), .s_data(s_data2),
        .stream_valid(stream_valid2), .stream_data(stream_data2), .stream_last(stream_last2),
        .match_valid(match_valid2), .match_vec(match_vec2),
        .res_valid(res_valid2), .res_ready(res_ready2), .res_base(res_base2), .res_vec(res_vec2),
        .state_dbg(state_dbg2)
    );

    // Clock and environment: memories answer one cycle after their strobes, junk otherwise.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_data  <= w_rd ? wmem[w_addr] : 8'($urandom);
        s_data  <= s_rd ? smem[s_addr] : 8'($urandom);
        w_data2 <= w_rd2 ? (8'(w_addr2) ^ 8'hA5) : 8'($urandom);
        s_data2 <= s_rd2 ? 8'(s_addr2) : 8'($urandom);
        if (done) done_cnt <= done_cnt + 1;
        if (load_en2) begin
            ld2_cnt <= ld2_cnt + 1;
            if (load_data2 !== (8'(load_slot2) ^ 8'hA5)) ld2_bad <= ld2_bad + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_w_rd"}, w_rd, 0);
        check({tag, "_w_addr"}, w_addr, 0);
        check({tag, "_load_en"}, load_en, 0);
        check({tag, "_load_slot"}, load_slot, 0);
        check({tag, "_load_data"}, load_data, 0);
        check({tag, "_slot_valid"}, slot_valid, 0);
        check({tag, "_s_rd"}, s_rd, 0);
        check({tag, "_s_addr"}, s_addr, 0);
        check({tag, "_stream_valid"}, stream_valid, 0);
        check({tag, "_stream_data"}, stream_data, 0);
        check({tag, "_stream_last"}, stream_last, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_base"}, res_base, 0);
        check({tag, "_res_vec"}, res_vec, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    task automatic fill_memories();
        foreach (wmem[i]) wmem[i] = 8'($urandom);
        foreach (smem[i]) smem[i] = 8'($urandom);
    endtask

    // One pass in lockstep: expected addresses, slot data, characters and the masked
    // result are all worked out from the pass number and the memory arrays.
    task automatic run_pass(input int p, input int rdy_delay, input bit rdy_pre,
                            input logic [15:0] mv, input bit mv_in_load,
                            input int abort_char, output bit aborted);
        int base, cnt, n;
        logic [15:0] mask;
        aborted = 1'b0;
        base = p * MW;
        cnt  = (WN - base < MW) ? (WN - base) : MW;
        mask = (cnt >= 16) ? 16'hFFFF : 16'((32'd1 << cnt) - 32'd1);
        n = 0;
        while (w_rd !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("load_start", w_rd, 1);
        for (int c = 0; c <= cnt; c++) begin
            check("w_rd", w_rd, (c < cnt) ? 1 : 0);
            if (c < cnt) check("w_addr", w_addr, base + c);
            check("load_en", load_en, (c > 0) ? 1 : 0);
            if (c > 0) begin
                check("load_slot", load_slot, c - 1);
                check("load_data", load_data, wmem[base + c - 1]);
            end
            check("busy_load", busy, 1);
            if (mv_in_load && c == 1) begin
                match_valid = 1'b1;
                match_vec   = 16'hFFFF;
            end else begin
                match_valid = 1'b0;
            end
            @(negedge clk);
        end
        match_valid = 1'b0;
        check("slot_valid", slot_valid, mask);
        for (int c = 0; c <= SL; c++) begin
            if (c == abort_char) begin
                #2 reset = 1'b0;
                #1 check_all_zero("async_reset");
                aborted = 1'b1;
                return;
            end
            check("s_rd", s_rd, (c < SL) ? 1 : 0);
            if (c < SL) check("s_addr", s_addr, c);
            check("stream_valid", stream_valid, (c > 0) ? 1 : 0);
            if (c > 0) check("stream_data", stream_data, smem[c - 1]);
            check("stream_last", stream_last, (c == SL) ? 1 : 0);
            @(negedge clk);
        end
        n = $urandom_range(0, 3);
        for (int i = 0; i <= n; i++) begin
            check("wait_res_valid", res_valid, 0);
            check("wait_s_rd", s_rd, 0);
            if (i < n) @(negedge clk);
        end
        if (rdy_pre) res_ready = 1'b1;
        match_valid = 1'b1;
        match_vec   = mv;
        @(negedge clk);
        match_valid = 1'b0;
        match_vec   = 16'($urandom);
        for (int d = 0; d < rdy_delay; d++) begin
            check("res_valid_hold", res_valid, 1);
            check("res_base_hold", res_base, base);
            check("res_vec_hold", res_vec, mv & mask);
            check("no_load_in_report", w_rd, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        check("res_valid", res_valid, 1);
        check("res_base", res_base, base);
        check("res_vec", res_vec, mv & mask);
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", res_valid, 0);
    endtask

    task automatic run_job(input bit hold_start, input bit mv_in_load, input int abort_char,
                           input int delay0, input bit pre_last, input bit ones_last);
        int d0;
        bit aborted;
        logic [15:0] mv;
        fill_memories();
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int p = 0; p < NP; p++) begin
            mv = (p == NP - 1 && ones_last) ? 16'hFFFF : 16'($urandom);
            run_pass(p, (p == 0) ? delay0 : 0, (p == NP - 1) ? pre_last : 1'b0,
                     mv, mv_in_load, (p == 0) ? abort_char : -1, aborted);
            if (aborted) begin
                start = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("post_reset_busy", busy, 0);
                    check("post_reset_res_valid", res_valid, 0);
                    check("post_reset_w_rd", w_rd, 0);
                end
                check("post_reset_done_cnt", done_cnt, d0);
                return;
            end
        end
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        start = 1'b0;
        @(negedge clk);
        check("done_low", done, 0);
        check("busy_low", busy, 0);
        check("done_count", done_cnt, d0 + 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_no_restart", w_rd, 0);
            check("idle_busy", busy, 0);
        end
        check("done_count_stable", done_cnt, d0 + 1);
    endtask

    initial begin
        int n;
        logic [15:0] mv2;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset_busy2", busy2, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_release", state_dbg, 0);

        run_job(1'b0, 1'b0, -1, 5, 1'b1, 1'b1);
        run_job(1'b1, 1'b1, -1, $urandom_range(0, 3), 1'b0, 1'b0);
        run_job(1'b0, 1'b0, 20, 0, 1'b0, 1'b0);
        run_job(1'b0, 1'b0, -1, $urandom_range(1, 6), 1'b1, 1'b0);

        mv2 = 16'($urandom);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (stream_last2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("single_stream_last", stream_last2, 1);
        check("single_last_char", stream_data2, SL2 - 1);
        @(negedge clk);
        match_valid2 = 1'b1;
        match_vec2   = mv2;
        @(negedge clk);
        match_valid2 = 1'b0;
        check("single_res_valid", res_valid2, 1);
        check("single_res_base", res_base2, 0);
        check("single_res_vec", res_vec2, mv2);
        check("single_slot_valid", slot_valid2, 16'hFFFF);
        check("single_load_count", ld2_cnt, 16);
        check("single_load_data", ld2_bad, 0);
        res_ready2 = 1'b1;
        @(negedge clk);
        res_ready2 = 1'b0;
        check("single_done", done2, 1);
        check("single_res_drop", res_valid2, 0);
        @(negedge clk);
        check("single_busy_low", busy2, 0);
        check("single_idle", state_dbg2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/match_scheduler.md
MATCH_SCHEDULER -- requirements
Module: match_scheduler

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, width of one character and one weight.
REQ-002 SHALL have parameter strlen, default 50, number of characters in the input string.
REQ-003 SHALL have parameter num, default 4, matcher slots per group.
REQ-004 SHALL have parameter groups, default 4, number of matcher groups.
REQ-005 SHALL have parameter max_number_of_weight, default num*groups (16), total matcher slots (MW).
REQ-006 SHALL have parameter weight_num, default 20, total weights to match (WN).
REQ-007 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-008 Port reset, input, 1, asynchronous, active-low reset.
REQ-009 Port start, input, 1, begin a full match job; sampled in IDLE only.
REQ-010 Port busy, output, 1, high from the cycle after an accepted start until DONE exits.
REQ-011 Port done, output, 1, one-cycle pulse at job end.
REQ-012 Port w_rd / w_addr, output, 1 / ceil(log2(WN)), weight-memory read strobe and index.
REQ-013 Port w_data, input, DWIDTH, weight-memory data, valid exactly 1 cycle after w_rd.
REQ-014 Port load_en / load_slot / load_data, output, 1 / ceil(log2(MW)) / DWIDTH, matcher slot write.
REQ-015 Port slot_valid, output, MW, bit k high = slot k holds a weight for the current pass.
REQ-016 Port s_rd / s_addr, output, 1 / ceil(log2(strlen)), string-memory read strobe and index.
REQ-017 Port s_data, input, DWIDTH, string data, valid 1 cycle after s_rd.
REQ-018 Port stream_valid / stream_data / stream_last, output, 1 / DWIDTH / 1, character stream to the matchers.
REQ-019 Port match_valid / match_vec, input, 1 / MW, matcher result for the finished pass.
REQ-020 Port res_valid / res_ready, output / input, 1 / 1, result handshake.
REQ-021 Port res_base / res_vec, output, ceil(log2(WN+1)) / MW, first weight index of the pass, masked match bits.

Function
REQ-022 States SHALL be IDLE, LOAD, STREAM, WAIT, REPORT, DONE.
REQ-023 IDLE: start=1 -> LOAD, base=0; start while not IDLE SHALL be ignored.
REQ-024 Pass size cnt SHALL be min(MW, WN-base); pass count = ceil(WN/MW) (2 with defaults).
REQ-025 LOAD entry SHALL clear slot_valid; w_rd high for cnt consecutive cycles with w_addr=base+k, k=0..cnt-1.
REQ-026 load_en SHALL assert the cycle after each w_rd with load_slot=k, load_data=w_data; slot_valid[k] sets the same edge.
REQ-027 LOAD SHALL last cnt+1 cycles, then go to STREAM.
REQ-028 STREAM: s_rd high strlen consecutive cycles, s_addr 0..strlen-1; stream_valid/stream_data follow 1 cycle later; stream_last high with index strlen-1 only; then WAIT.
REQ-029 WAIT: on match_valid, capture res_vec = match_vec & slot_valid, res_base=base, go to REPORT; match_valid outside WAIT SHALL be ignored.
REQ-030 REPORT: res_valid held with stable res_base/res_vec until res_ready; on handshake, base+=cnt; base>=WN -> DONE, else LOAD.
REQ-031 res_ready already high on entry SHALL complete the handshake in the first REPORT cycle.
REQ-032 DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
REQ-033 All strobes (w_rd, load_en, s_rd, stream_valid, stream_last, res_valid, done) SHALL be 0 outside their states.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, base=0, all outputs 0, including mid-pass; no partial result emitted after release.
REQ-035 First start SHALL be accepted no earlier than the first rising edge with reset=1.

Verification
REQ-036 Defaults, start pulse -> pass 1: 16 loads (w_addr 0..15), 50 chars, res_base=0; pass 2: 4 loads (w_addr 16..19), slot_valid=0x000F, res_base=16; done once.
REQ-037 Pass 2 match_vec=0xFFFF -> res_vec=0x000F.
REQ-038 res_ready low 5 cycles in REPORT -> res_valid, res_base, res_vec stable all 5 cycles; no LOAD until handshake.
REQ-039 reset low at STREAM char 20 -> all outputs 0 asynchronously; next start restarts at w_addr 0.
REQ-040 start held high through job -> exactly one job, one done; match_valid pulsed in LOAD -> no state change.
REQ-041 WN=16, MW=16 -> single pass, res_base=0, slot_valid=0xFFFF, done after first handshake.
